// File: rtl/iir_out_formatter_if.sv
// ============================================================================
// Module      : iir_out_formatter_if
// Description : Sample-in / formatted-sample-out streaming bundle for the
//               IIR output formatter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iir_out_formatter_if;
    logic        clk_en;
    logic [31:0] din;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output clk_en,
        output din,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  clk_en,
        input  din,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

`default_nettype wire

// File: rtl/iir_out_formatter.sv
// ============================================================================
// Module      : iir_out_formatter
// Description : Rounds, saturates and decimates 32-bit IIR samples to 16 bits
//               and buffers them in a small output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_out_formatter #(
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    iir_out_formatter_if.slave    bus,
    input  wire logic [4:0]       shift,
    input  wire logic [3:0]       decim,
    output      logic             sat_flag,
    output      logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic signed [32:0] C_MAX = 33'sd32767;
    localparam logic signed [32:0] C_MIN = -33'sd32768;
    localparam logic [CNT_W-1:0]   C_FULL = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Round half toward +inf, 33-bit so the bias add can never wrap
    // ------------------------------------------------------------------
    logic signed [32:0] w_ext;
    logic signed [32:0] w_bias;
    logic signed [32:0] w_sum;
    logic signed [32:0] w_rnd;
    logic               w_sat_hi;
    logic               w_sat_lo;
    logic        [15:0] w_fmt;

    assign w_ext    = {bus.din[31], bus.din};
    assign w_bias   = (shift != 5'd0) ? (33'sd1 <<< (shift - 5'd1)) : 33'sd0;
    assign w_sum    = w_ext + w_bias;
    assign w_rnd    = w_sum >>> shift;
    assign w_sat_hi = (w_rnd > C_MAX);
    assign w_sat_lo = (w_rnd < C_MIN);
    assign w_fmt    = w_sat_hi ? 16'h7FFF : (w_sat_lo ? 16'h8000 : w_rnd[15:0]);

    // ------------------------------------------------------------------
    // Decimation counter; decim is compared live so changes apply at once
    // ------------------------------------------------------------------
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       w_keep;

    assign w_keep = bus.clk_en && (cnt_q == 4'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.clk_en) begin
            cnt_d = (cnt_q >= decim) ? 4'd0 : cnt_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 and sticky saturation flag
    // ------------------------------------------------------------------
    logic        s1_keep_q;
    logic [15:0] s1_data_q;
    logic        sat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 4'd0;
            s1_keep_q <= 1'b0;
            s1_data_q <= 16'h0000;
            sat_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            s1_keep_q <= w_keep;
            if (bus.clk_en) begin
                s1_data_q <= w_fmt;
                if (w_sat_hi || w_sat_lo) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (stage 2 write side)
    // ------------------------------------------------------------------
    logic [15:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;
    logic             w_empty;
    logic             w_full;
    logic             w_rd;
    logic             w_wr;
    logic             w_drop;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == C_FULL);
    assign w_rd    = !w_empty && bus.out_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts
    assign w_wr    = s1_keep_q && (!w_full || w_rd);
    assign w_drop  = s1_keep_q && w_full && !w_rd;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_wr, w_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign sat_flag      = sat_q;
    assign overflow      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_iir_out_formatter.sv
// ============================================================================
// Module      : tb_iir_out_formatter
// Description : Self-checking bench for iir_out_formatter (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iir_out_formatter;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] shift = 5'd0;
    logic [3:0] decim = 4'd0;
    logic       sat_flag;
    logic       overflow;
    int         checks = 0;
    int         errors = 0;

    iir_out_formatter_if bus ();

    iir_out_formatter #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .shift    (shift),
        .decim    (decim),
        .sat_flag (sat_flag),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference formatter: exact integer rounding then clamping; bit 16 = saturated
    function automatic logic [16:0] ref_fmt(input logic [31:0] d, input int sh);
        longint v;
        v = longint'($signed(d));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.clk_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.clk_en = 1'b1;
        bus.din = 32'h0001_0000;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", bus.out_data); end
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat_flag); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        reset = 1'b0;
        bus.clk_en = 1'b0;
        tick();
    endtask

    task automatic test_rounding();
        logic [31:0] dins [4];
        logic [15:0] exps [4];
        dins = '{32'd24, -32'sd24, 32'd8, 32'd7};
        exps = '{16'h0002, 16'hFFFF, 16'h0001, 16'h0000};
        shift = 5'd4;
        decim = 4'd0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.clk_en = 1'b1;
            bus.din = dins[i];
            tick();
            bus.clk_en = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL round_latency%0d: out_valid got %b expected 0", i, bus.out_valid); end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exps[i]) begin
                errors++;
                $display("FAIL round%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.out_valid, bus.out_data, exps[i]);
            end
            tick();
        end
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL round_sat: got %b expected 0", sat_flag); end
    endtask

    task automatic test_saturation();
        shift = 5'd0;
        decim = 4'd0;
        bus.out_ready = 1'b1;
        bus.clk_en = 1'b1;
        bus.din = 32'h0001_0000;
        tick();
        bus.clk_en = 1'b0;
        checks++;
        if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b expected 1", sat_flag); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h7FFF) begin
            errors++; $display("FAIL sat_pos: got valid=%b data=%h expected valid=1 data=7fff", bus.out_valid, bus.out_data);
        end
        bus.clk_en = 1'b1;
        bus.din = 32'hFFFF_0000;
        tick();
        bus.clk_en = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h8000) begin
            errors++; $display("FAIL sat_neg: got valid=%b data=%h expected valid=1 data=8000", bus.out_valid, bus.out_data);
        end
        bus.clk_en = 1'b1;
        bus.din = 32'd100;
        tick();
        bus.clk_en = 1'b0;
        tick();
        tick();
        checks++;
        if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b expected 1", sat_flag); end
        do_reset();
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_cleared: got %b expected 0", sat_flag); end
    endtask

    task automatic test_decimation();
        logic [15:0] got [$];
        do_reset();
        shift = 5'd0;
        decim = 4'd3;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.clk_en = 1'b1;
            bus.din = i;
            tick();
            if (bus.out_valid) got.push_back(bus.out_data);
        end
        bus.clk_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) got.push_back(bus.out_data);
        end
        checks++;
        if (got.size() != 2) begin
            errors++; $display("FAIL decim_count: got %0d outputs expected 2", got.size());
        end else begin
            checks++;
            if (got[0] !== 16'd1 || got[1] !== 16'd5) begin
                errors++; $display("FAIL decim_values: got %0d,%0d expected 1,5", got[0], got[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got [$];
        do_reset();
        shift = 5'd0;
        decim = 4'd0;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.clk_en = 1'b1;
            bus.din = i;
            tick();
        end
        bus.clk_en = 1'b0;
        tick();
        tick();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd1) begin
                errors++; $display("FAIL bp_hold%0d: got valid=%b data=%h expected valid=1 data=0001", i, bus.out_valid, bus.out_data);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) got.push_back(bus.out_data);
            tick();
        end
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL bp_count: got %0d outputs expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== 16'(i + 1)) begin errors++; $display("FAIL bp_order%0d: got %0d expected %0d", i, got[i], i + 1); end
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got valid=%b expected 0", bus.out_valid); end
    endtask

    task automatic test_full_read();
        logic [15:0] got [$];
        logic [15:0] exp_seq [5];
        exp_seq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd9};
        do_reset();
        shift = 5'd0;
        decim = 4'd0;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.clk_en = 1'b1;
            bus.din = i;
            tick();
        end
        bus.clk_en = 1'b0;
        tick();
        tick();
        bus.clk_en = 1'b1;
        bus.din = 32'd9;
        tick();
        bus.clk_en = 1'b0;
        // Kept sample sits in stage 1 now; read in the same cycle it is written
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) got.push_back(bus.out_data);
            tick();
        end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL full_rd_overflow: got %b expected 0", overflow); end
        checks++;
        if (got.size() != 5) begin
            errors++; $display("FAIL full_rd_count: got %0d outputs expected 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== exp_seq[i]) begin errors++; $display("FAIL full_rd_order%0d: got %0d expected %0d", i, got[i], exp_seq[i]); end
            end
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        shift = 5'd0;
        decim = 4'd0;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.clk_en = 1'b1;
            bus.din = 32'h0010_0000;
            tick();
        end
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        reset = 1'b0;
        bus.clk_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush%0d: got valid=%b expected 0", i, bus.out_valid); end
            tick();
        end
        checks++;
        if (sat_flag !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL flush_flags: got sat=%b ovf=%b expected 0 0", sat_flag, overflow);
        end
    endtask

    task automatic test_random();
        logic [15:0] q [$];
        logic        pend_keep = 1'b0;
        logic [15:0] pend_val = 16'h0;
        logic        m_sat = 1'b0;
        logic        m_ovf = 1'b0;
        int          m_cnt = 0;
        logic [16:0] f;
        logic        rd;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                decim = 4'($urandom_range(0, 3));
                shift = 5'($urandom_range(0, 31));
            end
            if (i < 560) begin
                bus.clk_en = ($urandom % 4) != 0;
                bus.out_ready = ($urandom % 3) != 0;
            end else begin
                bus.clk_en = 1'b0;
                bus.out_ready = 1'b1;
            end
            if ($urandom % 4 == 0) bus.din = $urandom;
            else bus.din = 32'($signed($urandom_range(0, 400000)) - 200000);
            #1;
            checks++;
            if (bus.out_valid !== (q.size() > 0)) begin
                errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, bus.out_valid, q.size() > 0);
            end else if (q.size() > 0) begin
                checks++;
                if (bus.out_data !== q[0]) begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h", i, bus.out_data, q[0]); end
            end
            checks++;
            if (sat_flag !== m_sat || overflow !== m_ovf) begin
                errors++; $display("FAIL rnd_flags@%0d: got sat=%b ovf=%b expected sat=%b ovf=%b", i, sat_flag, overflow, m_sat, m_ovf);
            end
            // Advance the model across the coming clock edge
            rd = (q.size() > 0) && bus.out_ready;
            if (rd) void'(q.pop_front());
            if (pend_keep) begin
                if (q.size() < DEPTH) q.push_back(pend_val);
                else m_ovf = 1'b1;
            end
            f = ref_fmt(bus.din, int'(shift));
            pend_keep = bus.clk_en && (m_cnt == 0);
            pend_val = f[15:0];
            if (bus.clk_en) begin
                if (f[16]) m_sat = 1'b1;
                m_cnt = (m_cnt >= int'(decim)) ? 0 : m_cnt + 1;
            end
            tick();
        end
    endtask

    initial begin
        bus.clk_en = 1'b0;
        bus.din = 32'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_decimation();
        test_backpressure();
        test_full_read();
        test_reset_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iir_out_formatter.md
IIR_OUT_FORMATTER -- requirements
Module: iir_out_formatter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the output FIFO depth in entries (power of 2, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port clk_en, input, 1 bit: sample strobe; din is accepted on every cycle with clk_en=1.
REQ-005 The block SHALL have port din, input, 32 bits: signed two's-complement IIR filter output (dout of design_filt).
REQ-006 The block SHALL have port shift, input, 5 bits: right-shift amount applied before rounding (0..31).
REQ-007 The block SHALL have port decim, input, 4 bits: decimation factor minus one; 0 keeps every sample.
REQ-008 The block SHALL have port out_data, output, 16 bits: signed formatted sample at the FIFO head.
REQ-009 The block SHALL have port out_valid, output, 1 bit: high when the FIFO is non-empty.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accept; a transfer occurs when out_valid=1 and out_ready=1.
REQ-011 The block SHALL have port sat_flag, output, 1 bit: sticky flag set when any kept or discarded sample saturates.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag set when a kept sample is dropped because the FIFO is full.

Function
REQ-013 Rounding SHALL compute (din + (shift>0 ? 2^(shift-1) : 0)) >>> shift in 33-bit signed arithmetic, with no intermediate wrap (round half toward +inf).
REQ-014 Saturation SHALL clamp the rounded value to [-32768, 32767]; out-of-range values SHALL produce 0x7FFF or 0x8000 and set sat_flag.
REQ-015 The decimation counter SHALL start at 0, advance only on accepted samples, and wrap to 0 when counter >= decim; a sample SHALL be kept only when the counter is 0 at acceptance.
REQ-016 A change of decim mid-stream SHALL take effect on the next counter comparison; no sample SHALL be kept twice.
REQ-017 Stage 1 SHALL register the saturated value and keep bit one cycle after acceptance; stage 2 SHALL write a kept value into the FIFO.
REQ-018 Latency SHALL be 2 cycles: a kept sample accepted in cycle N into an empty FIFO SHALL appear with out_valid=1 in cycle N+2; there is no same-cycle fall-through.
REQ-019 The FIFO SHALL preserve order; out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 When the FIFO is full and a read occurs in the same cycle as a write, the write SHALL be accepted and overflow SHALL NOT set.
REQ-021 When the FIFO is full with no read, a kept write SHALL be discarded, overflow SHALL set, and FIFO contents SHALL be unchanged.
REQ-022 When the FIFO is empty, out_ready SHALL be ignored and the read pointer SHALL NOT move.
REQ-023 Discarded (non-kept) samples SHALL still update sat_flag but SHALL NOT write to the FIFO.

Reset
REQ-024 On reset=1 at a clock edge, the block SHALL set out_data=0, out_valid=0, sat_flag=0, and overflow=0, and clear the decimation counter, the stage-1 register, and the FIFO pointers and count.
REQ-025 Reset asserted mid-operation SHALL flush all buffered samples; in-flight pipeline samples SHALL be lost, and there SHALL be no output from them after reset.
REQ-026 While reset=1, clk_en and out_ready SHALL be ignored.

Verification
REQ-027 The bench SHALL check reset: hold reset for 2 cycles with clk_en=1 -> out_valid=0, out_data=0x0000, sat_flag=0, overflow=0.
REQ-028 The bench SHALL check rounding with shift=4, decim=0, out_ready=1: din=24 -> out_data=0x0002 at +2 cycles; din=-24 -> 0xFFFF; din=8 -> 0x0001; din=7 -> 0x0000.
REQ-029 The bench SHALL check saturation with shift=0: din=0x00010000 -> 0x7FFF and sat_flag=1; then din=0xFFFF0000 -> 0x8000; sat_flag stays 1 until reset.
REQ-030 The bench SHALL check decimation with decim=3, shift=0, samples 1..8 on consecutive clk_en cycles -> exactly two outputs, 1 then 5.
REQ-031 The bench SHALL check backpressure with DEPTH=4, out_ready=0, decim=0, and samples 1..6 -> overflow=1; then out_ready=1 -> outputs 1,2,3,4 in order, then out_valid=0.
REQ-032 The bench SHALL check full plus simultaneous read: FIFO holds 4 entries, out_ready=1 in the same cycle a kept sample arrives -> no overflow, and that sample is output last.
